quad_decoder: RTL and testbench

Quadrature position decoder. It is the receive-side counterpart of the up/down counter: it takes two-phase encoder signals (A/B), recovers direction (updn) and step events, and keeps a modulo position count with the same wrap rules and 5-bit count format. Inputs are asynchronous and may bounce. The block synchronizes, debounces and decodes them into single-cycle step/error strobes for downstream logic.

---
 rtl/quad_decoder_if.sv | 12 +
 rtl/quad_decoder.sv | 108 ++++++++++
 tb/tb_quad_decoder.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/quad_decoder_if.sv
// Encoder-side bundle for the quadrature decoder: raw A/B phases in, position and strobes out.
interface quad_decoder_if;
  logic       a_in;
  logic       b_in;
  logic [4:0] count;
  logic       updn;
  logic       step;
  logic       err;

  modport master (output a_in, b_in, input count, updn, step, err);
  modport slave  (input a_in, b_in, output count, updn, step, err);
endinterface

// File: rtl/quad_decoder.sv
// Quadrature decoder: 2-flop sync, debounce, x4 step decode into a modulo position count.
// Outputs are registered; a held input change lands 2+DEB_CYCLES edges after first sampling.
module quad_decoder #(
  parameter int CNT_LENGTH = 8,
  parameter int DEB_CYCLES = 4
) (
  input logic           clk,
  input logic           rst,
  quad_decoder_if.slave q
);

  localparam logic [4:0] CNT_MAX = 5'(CNT_LENGTH - 1);
  localparam logic [3:0] DEB_SAT = 4'(DEB_CYCLES);
  localparam logic [3:0] DEB_ACC = 4'(DEB_CYCLES - 2);

  typedef enum logic {INIT, TRACK} state_t;

  state_t     state;
  logic       a_s1, a_s2, b_s1, b_s2;
  logic [1:0] cand, stable;
  logic [3:0] deb_cnt;
  logic [4:0] count;
  logic       updn, step, err;

  logic [1:0] synced;
  logic       differ, accept;

  // Gray position along the up sequence 00->10->11->01.
  function automatic logic [1:0] phase(input logic [1:0] ab);
    case (ab)
      2'b00:   phase = 2'd0;
      2'b10:   phase = 2'd1;
      2'b11:   phase = 2'd2;
      default: phase = 2'd3;
    endcase
  endfunction

  // With a one-cycle debounce the first differing sample is itself accepted.
  always_comb begin
    synced = {a_s2, b_s2};
    differ = (synced != cand);
    accept = 1'b0;
    if (DEB_CYCLES == 1) accept = differ;
    else                 accept = !differ && (deb_cnt == DEB_ACC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_s1    <= 1'b0;
      a_s2    <= 1'b0;
      b_s1    <= 1'b0;
      b_s2    <= 1'b0;
      cand    <= 2'b00;
      stable  <= 2'b00;
      deb_cnt <= 4'd0;
      state   <= INIT;
      count   <= 5'd0;
      updn    <= 1'b1;
      step    <= 1'b0;
      err     <= 1'b0;
    end else begin
      a_s1 <= q.a_in;
      a_s2 <= a_s1;
      b_s1 <= q.b_in;
      b_s2 <= b_s1;
      step <= 1'b0;
      err  <= 1'b0;

      if (differ) begin
        cand    <= synced;
        deb_cnt <= 4'd0;
      end else if (deb_cnt != DEB_SAT) begin
        deb_cnt <= deb_cnt + 4'd1;
      end

      if (accept) begin
        case (state)
          INIT: begin
            stable <= synced;
            state  <= TRACK;
          end
          default: begin
            if (synced != stable) begin
              stable <= synced;
              if (phase(synced) == phase(stable) + 2'd1) begin
                count <= (count == CNT_MAX) ? 5'd0 : count + 5'd1;
                updn  <= 1'b1;
                step  <= 1'b1;
              end else if (phase(synced) + 2'd1 == phase(stable)) begin
                count <= (count == 5'd0) ? CNT_MAX : count - 5'd1;
                updn  <= 1'b0;
                step  <= 1'b1;
              end else begin
                err <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  assign q.count = count;
  assign q.updn  = updn;
  assign q.step  = step;
  assign q.err   = err;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder; expected step/err events are queued by the stimulus and popped by a monitor.
module tb_quad_decoder;

  typedef struct packed {
    logic       is_err;
    logic [4:0] count;
    logic       updn;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  ev_t  exp_q[$];

  quad_decoder_if vif();

  quad_decoder #(.CNT_LENGTH(8), .DEB_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .q   (vif.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic is_err, input logic [4:0] cnt, input logic ud);
    ev_t e;
    e.is_err = is_err;
    e.count  = cnt;
    e.updn   = ud;
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic [1:0] ab, input int n);
    vif.a_in = ab[1];
    vif.b_in = ab[0];
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] ab, input int n);
    rst = 1'b1;
    hold(ab, n);
    rst = 1'b0;
  endtask

  // Monitor: every strobe must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst && (vif.step || vif.err)) begin
      ev_t got, want;
      got.is_err = vif.err;
      got.count  = vif.count;
      got.updn   = vif.updn;
      n_checks++;
      if (vif.step && vif.err) begin
        n_fail++;
        $display("FAIL strobe_overlap: step=1 err=1 at count %0d", vif.count);
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: err=%0b count=%0d updn=%0b, none expected",
                 got.is_err, got.count, got.updn);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_fail++;
          $display("FAIL event: got err=%0b count=%0d updn=%0b expected err=%0b count=%0d updn=%0b",
                   got.is_err, got.count, got.updn, want.is_err, want.count, want.updn);
        end
      end
    end
  end

  initial begin
    vif.a_in = 1'b0;
    vif.b_in = 1'b0;
    @(posedge clk);
    #1;

    // 1: reset and idle
    do_reset(2'b00, 2);
    check("reset_count", 32'(vif.count), 0);
    check("reset_updn", 32'(vif.updn), 1);
    check("reset_step", 32'(vif.step), 0);
    hold(2'b00, 20);
    check("idle_count", 32'(vif.count), 0);
    check("idle_updn", 32'(vif.updn), 1);

    // 2: four up steps, first one checked for edge-6 latency
    push(0, 5'd1, 1);
    hold(2'b10, 5);
    check("lat_edge5_count", 32'(vif.count), 0);
    check("lat_edge5_step", 32'(vif.step), 0);
    hold(2'b10, 1);
    check("lat_edge6_count", 32'(vif.count), 1);
    check("lat_edge6_step", 32'(vif.step), 1);
    hold(2'b10, 4);
    push(0, 5'd2, 1); hold(2'b11, 10);
    push(0, 5'd3, 1); hold(2'b01, 10);
    push(0, 5'd4, 1); hold(2'b00, 10);
    check("up4_count", 32'(vif.count), 4);
    check("up4_updn", 32'(vif.updn), 1);

    // 3: down wrap 0->7, then 8 up steps wrapping 7->0
    do_reset(2'b00, 2);
    hold(2'b00, 10);
    push(0, 5'd7, 0); hold(2'b01, 10);
    check("down_wrap_count", 32'(vif.count), 7);
    check("down_wrap_updn", 32'(vif.updn), 0);
    do_reset(2'b00, 2);
    hold(2'b00, 10);
    push(0, 5'd1, 1); hold(2'b10, 10);
    push(0, 5'd2, 1); hold(2'b11, 10);
    push(0, 5'd3, 1); hold(2'b01, 10);
    push(0, 5'd4, 1); hold(2'b00, 10);
    push(0, 5'd5, 1); hold(2'b10, 10);
    push(0, 5'd6, 1); hold(2'b11, 10);
    push(0, 5'd7, 1); hold(2'b01, 10);
    push(0, 5'd0, 1); hold(2'b00, 10);
    check("up_wrap_count", 32'(vif.count), 0);

    // 4: glitch rejection (3 cycles) and minimal accepted pulse (4 cycles)
    hold(2'b10, 3);
    hold(2'b00, 10);
    check("glitch3_count", 32'(vif.count), 0);
    check("glitch3_updn", 32'(vif.updn), 1);
    push(0, 5'd1, 1);
    push(0, 5'd0, 0);
    hold(2'b10, 4);
    hold(2'b00, 10);
    check("pulse4_count", 32'(vif.count), 0);
    check("pulse4_updn", 32'(vif.updn), 0);

    // 5: illegal 00->11, then legal 11->01
    push(1, 5'd0, 0); hold(2'b11, 10);
    check("illegal_count", 32'(vif.count), 0);
    check("illegal_updn", 32'(vif.updn), 0);
    push(0, 5'd1, 1); hold(2'b01, 10);
    check("after_illegal_count", 32'(vif.count), 1);

    // 6: reach count 5 at AB=11 (start from absorbed 10), then reset mid-run
    do_reset(2'b10, 2);
    hold(2'b10, 10);
    check("absorb10_count", 32'(vif.count), 0);
    push(0, 5'd1, 1); hold(2'b11, 10);
    push(0, 5'd2, 1); hold(2'b01, 10);
    push(0, 5'd3, 1); hold(2'b00, 10);
    push(0, 5'd4, 1); hold(2'b10, 10);
    push(0, 5'd5, 1); hold(2'b11, 10);
    check("pre_reset_count", 32'(vif.count), 5);
    do_reset(2'b11, 1);
    check("midrst_count", 32'(vif.count), 0);
    check("midrst_updn", 32'(vif.updn), 1);
    hold(2'b11, 10);
    check("absorb11_count", 32'(vif.count), 0);
    push(0, 5'd1, 1); hold(2'b01, 10);
    check("final_count", 32'(vif.count), 1);
    check("final_updn", 32'(vif.updn), 1);

    hold(2'b01, 5);
    check("events_outstanding", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
